fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the LEGv8 single-cycle/pipelined core. Sits directly upstream of the 64-word instruction ROM.
- Holds the PC and drives the ROM word address. Captures the returned instruction into an IF/ID output register with a valid/ready handshake toward decode.
- Accepts branch redirects, stops at the end-of-program idiom (CBZ XZR,#0), and flags out-of-range or misaligned PCs.

Parameters:
- N, 64, PC / address width
- AW, 6, ROM word-address width (64 words)
- RESET_PC, 0, PC value after reset
- HALT_INSTR, 32'hb400001f, end-of-program encoding (CBZ XZR,#0)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- imem_addr  out  AW  word address to the ROM = pc[AW+1:2]
- imem_q  in  32  ROM data, combinational from imem_addr
- redirect  in  1  branch taken / flush request
- redirect_pc  in  N  branch target
- id_ready  in  1  decode accepts id_instr this cycle
- id_valid  out  1  id_instr/id_pc hold a valid instruction
- id_instr  out  32  fetched instruction
- id_pc  out  N  address of id_instr
- pc  out  N  current fetch PC
- halted  out  1  HALT state
- fault  out  1  ERR state
- fetch_count  out  32  instructions handed to decode (handshakes), saturating

Behaviour:
- Reset values (asynchronous, active-high):
  - pc=RESET_PC; id_valid=0; id_instr=0; id_pc=0; state=RUN; halted=0; fault=0; fetch_count=0.
- imem_addr is pure combinational from pc. The ROM is combinational, so imem_q is valid in the same cycle.
- States:
  - RUN: fetching.
  - HALT: halt instruction issued; no fetch.
  - ERR: bad PC; no fetch.
- slot_free = !id_valid || id_ready.
- pc_bad = (pc[1:0]!=0) || (pc[N-1:AW+2]!=0).
- Priority per cycle, highest first:
  1. redirect=1 (any state):
     - pc<=redirect_pc; id_valid<=0, squashing any held instruction even if id_ready=0; state<=RUN.
     - A handshake in that same cycle does not count in fetch_count.
  2. RUN && pc_bad:
     - state<=ERR; id_valid<=0 if slot_free, else the held instruction stays until accepted; pc holds.
  3. RUN && slot_free:
     - id_instr<=imem_q; id_pc<=pc; id_valid<=1.
     - If imem_q==HALT_INSTR: pc holds and state<=HALT. Otherwise pc<=pc+4.
  4. RUN && !slot_free: stall; pc and the output register hold unchanged.
  5. HALT/ERR && id_valid && id_ready: id_valid<=0. No new fetch.
- Latency: instruction at pc appears on id_instr one clock after the cycle it is addressed. Throughput is 1 per cycle while id_ready=1.
- halted=(state==HALT); fault=(state==ERR). Both are registered.
- fetch_count increments on id_valid&&id_ready&&!redirect. It saturates at 32'hffffffff.
- pc+4 is computed at N bits. Wrap past 0xFC produces 0x100, which is caught by the pc_bad check on the next cycle; no silent wrap to 0.
- Simultaneous redirect and halt capture: redirect wins and the halt word is not issued.
- Reset mid-stall or mid-ERR: all state returns to reset values asynchronously.

Decomposition:
- Package fetch_pkg holds:
  - the state enum {RUN, HALT, ERR}, 2 bits
  - HALT_INSTR default
  - the INSTR_BYTES=4 constant
- One sub-module: flopre (N-bit register with async active-high reset and enable), instantiated for pc and for the IF/ID register.
- FSM, next-PC logic and counter stay in fetch_stage.

Test Plan:
1. Reset, id_ready=1, ROM words 0..2 = 8b1e03c5, 8b0400a5, cb020042:
   - Cycle 1: id_valid=1, id_instr=8b1e03c5, id_pc=0.
   - Cycle 2: 8b0400a5 / 4. Cycle 3: cb020042 / 8.
   - imem_addr steps 0,1,2,3.
2. id_ready=0 for 3 cycles while holding id_pc=8:
   - id_instr stays cb020042, pc stays 0xC, fetch_count is unchanged.
   - Release: f8000002 / 0xC next.
3. While stalled, redirect=1 with redirect_pc=0x20:
   - Next cycle id_valid=0, pc=0x20.
   - Following cycle id_instr=b4ffff7f, id_pc=0x20.
4. Redirect to 0x50 (word 20 = b400001f):
   - id_instr=b400001f, halted=1, pc stays 0x50.
   - After accept id_valid=0 and stays 0.
   - A later redirect to 0 resumes RUN.
5. Error cases:
   - Redirect to 0x100: fault=1, id_valid=0, no fetch, fetch_count frozen.
   - Redirect to 0x6: fault=1.
   - Redirect to 0x4: fault=0, resumes.
6. Assert reset during ERR with a valid instruction held:
   - All outputs immediately at reset values, pc=RESET_PC, fetch_count=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg : shared types and constants for the LEGv8 instruction-fetch stage
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } fetch_state_e;

  // CBZ XZR,#0 : branches to itself forever, used as the end-of-program marker
  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hb400001f;
  localparam int          INSTR_BYTES        = 4;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_flopre.sv
// ---------------------------------------------------------------------------
// flopre : WIDTH-bit register, asynchronous active-high reset, load enable
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module flopre #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage : PC, ROM addressing and IF/ID register with valid/ready handshake
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          N          = 64,
  parameter int          AW         = 6,
  parameter logic [N-1:0] RESET_PC  = '0,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_q,
  input  logic          redirect,
  input  logic [N-1:0]  redirect_pc,
  input  logic          id_ready,
  output logic          id_valid,
  output logic [31:0]   id_instr,
  output logic [N-1:0]  id_pc,
  output logic [N-1:0]  pc,
  output logic          halted,
  output logic          fault,
  output logic [31:0]   fetch_count
);

  logic [N-1:0]  pc_q, pc_d;
  logic          pc_en;
  logic          cap_en;
  logic          id_valid_q, id_valid_d;
  logic [31:0]   count_q, count_d;
  logic          halted_q, fault_q;
  fetch_state_e  state_q, state_d;
  logic          slot_free;
  logic          pc_bad;

  flopre #(.WIDTH(N), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .d     (pc_d),
    .q     (pc_q)
  );

  flopre #(.WIDTH(32 + N), .RESET_VAL('0)) u_ifid_reg (
    .clk   (clk),
    .reset (reset),
    .en    (cap_en),
    .d     ({imem_q, pc_q}),
    .q     ({id_instr, id_pc})
  );

  assign imem_addr = pc_q[AW+1:2];
  assign slot_free = !id_valid_q || id_ready;
  // Anything beyond the ROM or not word aligned is caught here, including pc+4 overflowing past the last word.
  assign pc_bad    = (pc_q[1:0] != 2'b00) || (pc_q[N-1:AW+2] != '0);

  always_comb begin
    pc_d       = pc_q;
    pc_en      = 1'b0;
    cap_en     = 1'b0;
    id_valid_d = id_valid_q;
    state_d    = state_q;
    if (redirect) begin
      pc_d       = redirect_pc;
      pc_en      = 1'b1;
      id_valid_d = 1'b0;
      state_d    = ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (pc_bad) begin
        state_d = ST_ERR;
        if (slot_free) id_valid_d = 1'b0;
      end else if (slot_free) begin
        cap_en     = 1'b1;
        id_valid_d = 1'b1;
        if (imem_q == HALT_INSTR) begin
          state_d = ST_HALT;
        end else begin
          pc_d  = pc_q + N'(INSTR_BYTES);
          pc_en = 1'b1;
        end
      end
    end else if (id_valid_q && id_ready) begin
      id_valid_d = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (id_valid_q && id_ready && !redirect && (count_q != 32'hffff_ffff)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      id_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      id_valid_q <= id_valid_d;
      halted_q   <= (state_d == ST_HALT);
      fault_q    <= (state_d == ST_ERR);
      count_q    <= count_d;
    end
  end

  assign pc          = pc_q;
  assign id_valid    = id_valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage : directed scenarios plus randomized traffic vs. reference model
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] HALT_W = 32'hb400001f;
  localparam int M_RUN  = 0;
  localparam int M_HALT = 1;
  localparam int M_ERR  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [63:0] pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] rom [64];
  assign imem_q = rom[imem_addr];

  int n_checks = 0;
  int n_fails  = 0;

  // reference model state
  logic [63:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [63:0] m_pcid;
  int          m_mode;
  logic [31:0] m_count;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_q      (imem_q),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .pc          (pc),
    .halted      (halted),
    .fault       (fault),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 64'd0; m_valid = 1'b0; m_instr = 32'd0; m_pcid = 64'd0;
    m_mode = M_RUN; m_count = 32'd0;
  endtask

  // Drive one cycle of inputs, advance the model by one clock, then sample #1 after the edge.
  task automatic step(input logic rd, input logic [63:0] rpc, input logic rdy);
    logic        hs;
    logic [31:0] w;
    redirect = rd; redirect_pc = rpc; id_ready = rdy;
    hs = m_valid && rdy;
    if (hs && !rd && m_count != 32'hffff_ffff) m_count = m_count + 1;
    if (rd) begin
      m_pc = rpc; m_valid = 1'b0; m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if ((m_pc % 4 != 0) || (m_pc >= 64'd256)) begin
        m_mode = M_ERR;
        if (!m_valid || rdy) m_valid = 1'b0;
      end else if (!m_valid || rdy) begin
        w = rom[m_pc / 4];
        m_instr = w; m_pcid = m_pc; m_valid = 1'b1;
        if (w == HALT_W) m_mode = M_HALT;
        else m_pc = m_pc + 4;
      end
    end else if (hs) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    #2;
    model_reset();
    n_checks++; if (pc !== 64'd0) begin n_fails++; $display("FAIL reset_pc got=%h exp=0", pc); end
    n_checks++; if (id_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
    n_checks++; if (id_instr !== 32'd0 || id_pc !== 64'd0) begin n_fails++; $display("FAIL reset_ifid got=%h/%h exp=0/0", id_instr, id_pc); end
    n_checks++; if (halted !== 1'b0 || fault !== 1'b0) begin n_fails++; $display("FAIL reset_flags got=%b%b exp=00", halted, fault); end
    n_checks++; if (fetch_count !== 32'd0) begin n_fails++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    logic [31:0] exp_i [3];
    exp_i[0] = 32'h8b1e03c5; exp_i[1] = 32'h8b0400a5; exp_i[2] = 32'hcb020042;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (imem_addr !== 6'(k)) begin n_fails++; $display("FAIL fetch_addr%0d got=%0d exp=%0d", k, imem_addr, k); end
      step(1'b0, '0, 1'b1);
      n_checks++;
      if (id_valid !== 1'b1 || id_instr !== exp_i[k] || id_pc !== 64'(4*k)) begin
        n_fails++; $display("FAIL fetch%0d got=%b/%h/%h exp=1/%h/%h", k, id_valid, id_instr, id_pc, exp_i[k], 64'(4*k));
      end
    end
    n_checks++; if (imem_addr !== 6'd3) begin n_fails++; $display("FAIL fetch_addr3 got=%0d exp=3", imem_addr); end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, 1'b0);
      n_checks++;
      if (id_instr !== 32'hcb020042 || id_pc !== 64'h8 || pc !== 64'hc || fetch_count !== m_count || !id_valid) begin
        n_fails++; $display("FAIL stall%0d got=%h/%h pc=%h cnt=%0d exp=cb020042/8 pc=c cnt=%0d", k, id_instr, id_pc, pc, fetch_count, m_count);
      end
    end
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (id_instr !== 32'hf8000002 || id_pc !== 64'hc || fetch_count !== m_count) begin
      n_fails++; $display("FAIL stall_release got=%h/%h cnt=%0d exp=f8000002/c cnt=%0d", id_instr, id_pc, fetch_count, m_count);
    end
  endtask

  task automatic test_redirect_stall();
    step(1'b0, '0, 1'b0);
    step(1'b1, 64'h20, 1'b0);
    n_checks++;
    if (id_valid !== 1'b0 || pc !== 64'h20) begin n_fails++; $display("FAIL redir_squash got=%b pc=%h exp=0 pc=20", id_valid, pc); end
    n_checks++;
    if (fetch_count !== m_count) begin n_fails++; $display("FAIL redir_count got=%0d exp=%0d", fetch_count, m_count); end
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (id_valid !== 1'b1 || id_instr !== 32'hb4ffff7f || id_pc !== 64'h20) begin
      n_fails++; $display("FAIL redir_fetch got=%b/%h/%h exp=1/b4ffff7f/20", id_valid, id_instr, id_pc);
    end
  endtask

  task automatic test_halt();
    step(1'b1, 64'h50, 1'b1);
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (id_instr !== HALT_W || halted !== 1'b1 || pc !== 64'h50 || id_valid !== 1'b1) begin
      n_fails++; $display("FAIL halt_issue got=%h halted=%b pc=%h v=%b exp=%h halted=1 pc=50 v=1", id_instr, halted, pc, id_valid, HALT_W);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, 1'b1);
      n_checks++;
      if (id_valid !== 1'b0 || halted !== 1'b1 || pc !== 64'h50) begin
        n_fails++; $display("FAIL halt_idle%0d got=v%b h%b pc=%h exp=v0 h1 pc=50", k, id_valid, halted, pc);
      end
    end
    n_checks++; if (fetch_count !== m_count) begin n_fails++; $display("FAIL halt_count got=%0d exp=%0d", fetch_count, m_count); end
    step(1'b1, 64'h0, 1'b1);
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (halted !== 1'b0 || id_instr !== 32'h8b1e03c5 || id_valid !== 1'b1) begin
      n_fails++; $display("FAIL halt_resume got=h%b %h v%b exp=h0 8b1e03c5 v1", halted, id_instr, id_valid);
    end
  endtask

  task automatic test_errors();
    logic [31:0] cnt0;
    step(1'b1, 64'h100, 1'b1);
    cnt0 = fetch_count;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, 1'b1);
      n_checks++;
      if (fault !== 1'b1 || id_valid !== 1'b0 || pc !== 64'h100 || fetch_count !== cnt0) begin
        n_fails++; $display("FAIL err_range%0d got=f%b v%b pc=%h cnt=%0d exp=f1 v0 pc=100 cnt=%0d", k, fault, id_valid, pc, fetch_count, cnt0);
      end
    end
    step(1'b1, 64'h6, 1'b1);
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (fault !== 1'b1 || id_valid !== 1'b0) begin n_fails++; $display("FAIL err_align got=f%b v%b exp=f1 v0", fault, id_valid); end
    step(1'b1, 64'h4, 1'b1);
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (fault !== 1'b0 || id_instr !== 32'h8b0400a5 || id_pc !== 64'h4 || id_valid !== 1'b1) begin
      n_fails++; $display("FAIL err_recover got=f%b %h/%h v%b exp=f0 8b0400a5/4 v1", fault, id_instr, id_pc, id_valid);
    end
  endtask

  task automatic test_reset_in_err();
    step(1'b1, 64'hfc, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    n_checks++;
    if (fault !== 1'b1 || id_valid !== 1'b1 || id_pc !== 64'hfc || pc !== 64'h100) begin
      n_fails++; $display("FAIL err_hold got=f%b v%b idpc=%h pc=%h exp=f1 v1 idpc=fc pc=100", fault, id_valid, id_pc, pc);
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (pc !== 64'd0 || id_valid !== 1'b0 || id_instr !== 32'd0 || id_pc !== 64'd0 ||
        fault !== 1'b0 || halted !== 1'b0 || fetch_count !== 32'd0) begin
      n_fails++; $display("FAIL async_reset got=pc%h v%b %h/%h f%b h%b cnt=%0d exp=all zero",
                          pc, id_valid, id_instr, id_pc, fault, halted, fetch_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic        rd, rdy;
    logic [63:0] tgt;
    for (int k = 0; k < 5; k++) rom[$urandom_range(4, 63)] = HALT_W;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rd  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = {56'd0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 7) == 0) tgt = ($urandom_range(0, 1) == 1) ? tgt + 64'h100 : tgt | 64'h2;
      n_checks++;
      if (imem_addr !== m_pc[7:2]) begin n_fails++; $display("FAIL rnd_addr cyc=%0d got=%0d exp=%0d", cyc, imem_addr, m_pc[7:2]); end
      step(rd, tgt, rdy);
      n_checks++;
      if (pc !== m_pc) begin n_fails++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, pc, m_pc); end
      n_checks++;
      if (id_valid !== m_valid) begin n_fails++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, id_valid, m_valid); end
      n_checks++;
      if (id_instr !== m_instr || id_pc !== m_pcid) begin
        n_fails++; $display("FAIL rnd_ifid cyc=%0d got=%h/%h exp=%h/%h", cyc, id_instr, id_pc, m_instr, m_pcid);
      end
      n_checks++;
      if (halted !== (m_mode == M_HALT) || fault !== (m_mode == M_ERR)) begin
        n_fails++; $display("FAIL rnd_state cyc=%0d got=h%b f%b exp_mode=%0d", cyc, halted, fault, m_mode);
      end
      n_checks++;
      if (fetch_count !== m_count) begin n_fails++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, fetch_count, m_count); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom[i] = $urandom;
      if (rom[i] == HALT_W) rom[i] = ~HALT_W;
    end
    rom[0]  = 32'h8b1e03c5;
    rom[1]  = 32'h8b0400a5;
    rom[2]  = 32'hcb020042;
    rom[3]  = 32'hf8000002;
    rom[8]  = 32'hb4ffff7f;
    rom[20] = HALT_W;
    rom[63] = 32'h8b1f03e0;

    test_reset();
    test_fetch();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_errors();
    test_reset_in_err();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
